// File: rtl/spi_block_assembler_if.sv
// Byte-stream / block handshake bundle between the SPI slave, the assembler and the AES consumer.
interface spi_block_assembler_if;
  logic         byte_done;
  logic [7:0]   byte_in;
  logic [127:0] block_out;
  logic         block_valid;
  logic         block_ready;
  logic         busy;
  logic [4:0]   byte_count;
  logic         timeout_err;
  logic         overrun_err;

  modport slave (
    input  byte_done, byte_in, block_ready,
    output block_out, block_valid, busy, byte_count, timeout_err, overrun_err
  );

  modport master (
    output byte_done, byte_in, block_ready,
    input  block_out, block_valid, busy, byte_count, timeout_err, overrun_err
  );
endinterface

// File: rtl/spi_block_assembler.sv
// Assembles 16 SPI bytes into a 128-bit block (first byte in [127:120]) with a
// valid/ready output handshake and a per-byte inactivity timeout on partial blocks.
module spi_block_assembler #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  spi_block_assembler_if.slave  bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           done_q;
  logic [127:0]   block_q, block_d;
  logic [4:0]     count_q, count_d;
  logic [TW-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic           valid_q, busy_q;
  logic           tmo_err_q, tmo_err_d;
  logic           ovr_err_q, ovr_err_d;
  logic           byte_ev;

  assign byte_ev = bus.byte_done & ~done_q;

  always_comb begin
    state_d   = state_q;
    block_d   = block_q;
    count_d   = count_q;
    tmo_cnt_d = '0;
    tmo_err_d = 1'b0;
    ovr_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (byte_ev) begin
          block_d = {block_q[119:0], bus.byte_in};
          count_d = 5'd1;
          state_d = FILL;
        end
      end
      FILL: begin
        if (byte_ev) begin
          block_d = {block_q[119:0], bus.byte_in};
          count_d = count_q + 5'd1;
          if (count_q == 5'd15) state_d = FULL;
        end else if (tmo_cnt_q == TMO_LAST) begin
          // Counter holds cycles already elapsed, so firing on LAST lands the
          // pulse exactly TIMEOUT_CYCLES edges after the last accepted byte.
          block_d   = '0;
          count_d   = '0;
          tmo_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      FULL: begin
        if (valid_q && bus.block_ready) begin
          if (byte_ev) begin
            block_d = {block_q[119:0], bus.byte_in};
            count_d = 5'd1;
            state_d = FILL;
          end else begin
            count_d = '0;
            state_d = IDLE;
          end
        end else if (byte_ev) begin
          ovr_err_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        block_d = '0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      done_q    <= 1'b1;
      block_q   <= '0;
      count_q   <= '0;
      tmo_cnt_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      tmo_err_q <= 1'b0;
      ovr_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= bus.byte_done;
      block_q   <= block_d;
      count_q   <= count_d;
      tmo_cnt_q <= tmo_cnt_d;
      valid_q   <= (state_d == FULL);
      busy_q    <= (state_d == FILL);
      tmo_err_q <= tmo_err_d;
      ovr_err_q <= ovr_err_d;
    end
  end

  assign bus.block_out   = block_q;
  assign bus.block_valid = valid_q;
  assign bus.busy        = busy_q;
  assign bus.byte_count  = count_q;
  assign bus.timeout_err = tmo_err_q;
  assign bus.overrun_err = ovr_err_q;

endmodule
